pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//  Parametrised, flow-controlled pipeline register between any two pipeline stages (issue->ex, ex->mem, ...).
//  Carries an opaque DATA_W-bit payload with a valid/ready handshake and a 2-entry skid buffer.
//  Sustains 1 transfer/cycle with ready_o registered, so no combinational ready path crosses the stage.
//  Adds stall via ready_i backpressure and a synchronous flush that kills in-flight entries.
// PARAMETERS
//  DATA_W      32  payload width in bits (>=1)
//  CLEAR_DATA  1   1: data regs zeroed on flush; 0: data regs hold, only valid bits cleared
// PORTS
//  clk       in   1        clock, all state on rising edge
//  reset     in   1        asynchronous, active-high reset
//  flush_i   in   1        synchronous kill of all held entries (branch mispredict/exception)
//  valid_i   in   1        upstream entry valid
//  ready_o   out  1        stage can accept (registered)
//  data_i    in   DATA_W   upstream payload
//  valid_o   out  1        downstream entry valid (registered)
//  ready_i   in   1        downstream accepts; 0 = stall
//  data_o    out  DATA_W   downstream payload (registered, main entry)
//  count_o   out  2        held entries: 0, 1 or 2
// BEHAVIOUR
//  in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
//  Reset (async assert, sync deassert): state=EMPTY, valid_o=0, ready_o=0, data_o=0, skid=0, count_o=0.
//  ready_o rises the first clock after reset release; next ready_o = (next_state != FULL).
//  States (main=output reg, skid=overflow reg):
//   EMPTY: valid_o=0. in_fire -> BUSY, main<=data_i.
//   BUSY : valid_o=1.
//          out_fire & !in_fire -> EMPTY.
//          in_fire & !out_fire -> FULL, skid<=data_i.
//          in_fire & out_fire  -> BUSY, main<=data_i.
//          neither -> hold.
//   FULL : ready_o=0, so in_fire is impossible. out_fire -> BUSY, main<=skid; else hold.
//  Latency: in_fire in EMPTY -> valid_o/data_o next cycle (1 cycle).
//  Ordering is strictly FIFO: skid content never overtakes main.
//  Stall: ready_i=0 never drops or duplicates data; data_o is stable while valid_o=1 and !ready_i.
//  Flush: highest priority. Next state EMPTY, valid_o=0, count_o=0, ready_o=1.
//   An in_fire or out_fire in the flush cycle completes at the handshake level, but the input payload is discarded.
//   CLEAR_DATA=1 also zeroes main and skid.
//  Simultaneous flush & reset: reset wins.
//  Reset mid-transfer: all entries lost; no output pulse.
//  count_o: EMPTY=0, BUSY=1, FULL=2. Always consistent with valid_o (valid_o = count_o!=0).
//  X-safety: data regs load only on the fire conditions above; valid_o never X after reset.
// STRUCTURE
//  Shared package pipe_pkg holds the state encoding (PS_EMPTY=2'd0, PS_BUSY=2'd1, PS_FULL=2'd2)
//   and the DATA_W defaults for each stage payload bundle.
//  Stage payload bundles are concatenated by the instantiating stage, not here.
//  Single flat module. No sub-module is natural: the skid entry is one register with an enable.
//  One state register, a 2nd-stage next-state always block, one async-reset sequential block.
// TESTING
//  1 Reset: assert reset mid-cycle -> valid_o=0, ready_o=0, count_o=0 immediately;
//    ready_o=1 one clk after release.
//  2 Streaming: ready_i=1, valid_i=1, data 0x1..0x10 -> data_o 0x1..0x10 on consecutive cycles,
//    1-cycle latency, count_o=1 throughout.
//  3 Stall/skid: send 0xA,0xB with ready_i=0 -> count_o=2, ready_o=0, data_o=0xA held;
//    release ready_i -> 0xA then 0xB out, ready_o=1 after 0xA leaves.
//  4 Flush in FULL with valid_i=1 (0xC) -> next cycle valid_o=0, count_o=0, 0xC never appears;
//    CLEAR_DATA=1 -> data_o=0; CLEAR_DATA=0 -> data_o holds 0xA.
//  5 Random valid_i/ready_i (10k cycles, DATA_W=1 and 96) vs scoreboard -> no loss, dup or reorder;
//    data_o stable under stall.
//  6 Flush same cycle as out_fire (data 0x5 at output) -> 0x5 counts as consumed, stage EMPTY next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: the handshake state encoding and the
// default payload widths used by each stage bundle.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_BUSY  = 2'd1,
      PS_FULL  = 2'd2
   } pipe_state_e;

   localparam int DEFAULT_DATA_W = 32;
   localparam int ISSUE_DATA_W   = 32;
   localparam int EX_DATA_W      = 32;
   localparam int MEM_DATA_W     = 64;

   // Number of entries held in a given state.
   function automatic logic [1:0] state_count(input pipe_state_e s);
      logic [1:0] n;
      case (s)
         PS_EMPTY: n = 2'd0;
         PS_BUSY:  n = 2'd1;
         PS_FULL:  n = 2'd2;
         default:  n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Flow-controlled pipeline register with a two-entry skid buffer; ready_o is
// registered so no combinational ready path crosses the stage boundary.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        count_o
);

   pipe_state_e       state_r;
   pipe_state_e       state_next_s;
   logic              valid_r;
   logic              ready_r;
   logic [1:0]        count_r;
   logic [DATA_W-1:0] main_r;
   logic [DATA_W-1:0] skid_r;

   logic              in_fire_s;
   logic              out_fire_s;
   logic              load_main_s;
   logic              main_from_skid_s;
   logic              load_skid_s;
   logic              clear_s;

   assign in_fire_s  = valid_i & ready_r;
   assign out_fire_s = valid_r & ready_i;

   // Next-state and register-enable decode; flush overrides every transition.
   always_comb begin
      state_next_s     = state_r;
      load_main_s      = 1'b0;
      main_from_skid_s = 1'b0;
      load_skid_s      = 1'b0;
      clear_s          = 1'b0;
      if (flush_i) begin
         state_next_s = PS_EMPTY;
         clear_s      = CLEAR_DATA;
      end else begin
         case (state_r)
            PS_EMPTY: begin
               if (in_fire_s) begin
                  state_next_s = PS_BUSY;
                  load_main_s  = 1'b1;
               end else begin
                  state_next_s = PS_EMPTY;
               end
            end
            PS_BUSY: begin
               if (in_fire_s && out_fire_s) begin
                  state_next_s = PS_BUSY;
                  load_main_s  = 1'b1;
               end else if (in_fire_s) begin
                  state_next_s = PS_FULL;
                  load_skid_s  = 1'b1;
               end else if (out_fire_s) begin
                  state_next_s = PS_EMPTY;
               end else begin
                  state_next_s = PS_BUSY;
               end
            end
            PS_FULL: begin
               // ready_o is low here, so only the drain path matters
               if (out_fire_s) begin
                  state_next_s     = PS_BUSY;
                  load_main_s      = 1'b1;
                  main_from_skid_s = 1'b1;
               end else begin
                  state_next_s = PS_FULL;
               end
            end
            default: begin
               state_next_s = PS_EMPTY;
            end
         endcase
      end
   end

   // State, registered handshake outputs and payload registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= PS_EMPTY;
         valid_r <= 1'b0;
         ready_r <= 1'b0;
         count_r <= 2'd0;
         main_r  <= {DATA_W{1'b0}};
         skid_r  <= {DATA_W{1'b0}};
      end else begin
         state_r <= state_next_s;
         valid_r <= (state_next_s != PS_EMPTY);
         ready_r <= (state_next_s != PS_FULL);
         count_r <= state_count(state_next_s);
         if (clear_s) begin
            main_r <= {DATA_W{1'b0}};
            skid_r <= {DATA_W{1'b0}};
         end else begin
            if (load_main_s) begin
               main_r <= main_from_skid_s ? skid_r : data_i;
            end else begin
               main_r <= main_r;
            end
            if (load_skid_s) begin
               skid_r <= data_i;
            end else begin
               skid_r <= skid_r;
            end
         end
      end
   end

   assign valid_o = valid_r;
   assign ready_o = ready_r;
   assign count_o = count_r;
   assign data_o  = main_r;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: four instances (widths 32/1/96, both flush-clear
// modes) share one stimulus stream and are compared against a queue model.
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_i = 1'b0;
   logic [95:0] data_in = 96'd0;

   logic        rdy_c, vld_c, rdy_h, vld_h, rdy_1, vld_1, rdy_w, vld_w;
   logic [1:0]  cnt_c, cnt_h, cnt_1, cnt_w;
   logic [31:0] dat_c, dat_h;
   logic [0:0]  dat_1;
   logic [95:0] dat_w;

   always #5 clk = ~clk;

   pipe_skid_reg #(.DATA_W(32), .CLEAR_DATA(1'b1)) dut_clr (
      .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy_c),
      .data_i(data_in[31:0]), .valid_o(vld_c), .ready_i(ready_i), .data_o(dat_c), .count_o(cnt_c));
   pipe_skid_reg #(.DATA_W(32), .CLEAR_DATA(1'b0)) dut_hold (
      .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy_h),
      .data_i(data_in[31:0]), .valid_o(vld_h), .ready_i(ready_i), .data_o(dat_h), .count_o(cnt_h));
   pipe_skid_reg #(.DATA_W(1), .CLEAR_DATA(1'b1)) dut_w1 (
      .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy_1),
      .data_i(data_in[0:0]), .valid_o(vld_1), .ready_i(ready_i), .data_o(dat_1), .count_o(cnt_1));
   pipe_skid_reg #(.DATA_W(96), .CLEAR_DATA(1'b1)) dut_w96 (
      .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy_w),
      .data_i(data_in), .valid_o(vld_w), .ready_i(ready_i), .data_o(dat_w), .count_o(cnt_w));

   // Reference: FIFO of held entries, plus what the output register shows when empty.
   logic [95:0] q[$];
   logic        m_ready = 1'b0;
   logic [95:0] m_main_clr = 96'd0;
   logic [95:0] m_main_hold = 96'd0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [95:0] ev, er, ec;
      ev = {95'd0, (q.size() != 0)};
      er = {95'd0, m_ready};
      ec = 96'(q.size());
      check_eq("clr.valid", {95'd0, vld_c}, ev);
      check_eq("clr.ready", {95'd0, rdy_c}, er);
      check_eq("clr.count", {94'd0, cnt_c}, ec);
      check_eq("clr.data",  {64'd0, dat_c}, {64'd0, m_main_clr[31:0]});
      check_eq("hold.valid", {95'd0, vld_h}, ev);
      check_eq("hold.ready", {95'd0, rdy_h}, er);
      check_eq("hold.count", {94'd0, cnt_h}, ec);
      check_eq("hold.data",  {64'd0, dat_h}, {64'd0, m_main_hold[31:0]});
      check_eq("w1.valid", {95'd0, vld_1}, ev);
      check_eq("w1.ready", {95'd0, rdy_1}, er);
      check_eq("w1.count", {94'd0, cnt_1}, ec);
      check_eq("w1.data",  {95'd0, dat_1}, {95'd0, m_main_clr[0]});
      check_eq("w96.valid", {95'd0, vld_w}, ev);
      check_eq("w96.ready", {95'd0, rdy_w}, er);
      check_eq("w96.count", {94'd0, cnt_w}, ec);
      check_eq("w96.data",  dat_w, m_main_clr);
   endtask

   // Drive one cycle, advance the model across the edge, then compare.
   task automatic step(input logic v, input logic r, input logic f, input logic [95:0] d);
      logic in_f, out_f;
      valid_i = v;
      ready_i = r;
      flush_i = f;
      data_in = d;
      in_f  = v & m_ready;
      out_f = (q.size() != 0) & r;
      if (f) begin
         q.delete();
         m_main_clr = 96'd0;
      end else begin
         if (out_f) void'(q.pop_front());
         if (in_f) q.push_back(d);
      end
      if (q.size() != 0) begin
         m_main_clr  = q[0];
         m_main_hold = q[0];
      end
      m_ready = (q.size() < 2);
      @(posedge clk);
      #1;
      check_all();
   endtask

   // Assert reset mid-cycle, check immediate effect, release at a falling edge.
   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      q.delete();
      m_ready     = 1'b0;
      m_main_clr  = 96'd0;
      m_main_hold = 96'd0;
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      step(1'b1, 1'b1, 1'b0, 96'h55);
      check_eq("ready_after_release", {95'd0, rdy_c}, 96'd1);

      for (int i = 1; i <= 16; i++) step(1'b1, 1'b1, 1'b0, 96'(i));
      step(1'b0, 1'b1, 1'b0, 96'd0);

      step(1'b1, 1'b0, 1'b0, 96'hA);
      step(1'b1, 1'b0, 1'b0, 96'hB);
      step(1'b1, 1'b0, 1'b0, 96'hC);
      step(1'b0, 1'b0, 1'b0, 96'd0);
      step(1'b0, 1'b1, 1'b0, 96'd0);
      step(1'b0, 1'b1, 1'b0, 96'd0);

      step(1'b1, 1'b0, 1'b0, 96'hA);
      step(1'b1, 1'b0, 1'b0, 96'hB);
      step(1'b1, 1'b0, 1'b1, 96'hC);
      check_eq("flush_full.hold_data", {64'd0, dat_h}, 96'hA);
      check_eq("flush_full.clr_data", {64'd0, dat_c}, 96'h0);
      step(1'b0, 1'b1, 1'b0, 96'd0);

      step(1'b1, 1'b1, 1'b0, 96'h5);
      step(1'b0, 1'b1, 1'b1, 96'd0);
      step(1'b1, 1'b1, 1'b1, 96'h7);
      step(1'b0, 1'b1, 1'b0, 96'd0);

      step(1'b1, 1'b0, 1'b0, 96'h9);
      step(1'b1, 1'b0, 1'b0, 96'h19);
      do_reset();
      step(1'b0, 1'b1, 1'b0, 96'd0);

      for (int i = 0; i < 10000; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 31) == 0),
              {$urandom(), $urandom(), $urandom()});
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
